// File: rtl/regfile_pkg.sv
// Shared defaults and FSM encoding for the register file access controller.
// No logic, no latency.
// No flow control of its own; consumers handle backpressure.
package regfile_pkg;

    localparam int DEF_WORD_SIZE     = 64;
    localparam int DEF_REG_ADDR_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard of in-flight destination registers with hazard query.
// Hazard is combinational; busy bits update at the next rising edge.
// No backpressure: set and clear are always taken, set wins on collision.
module regfile_scoreboard #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    input  logic [ADDR_W-1:0] q_rd,
    input  logic              q_wr,
    output logic              hazard
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        // A register retiring this cycle is already written by the next read.
        busy_eff  = busy_q & ~clr_mask;
        busy_d    = busy_eff | set_mask;
        busy_d[0] = 1'b0;
        hazard    = busy_eff[q_rs1] | busy_eff[q_rs2] | (q_wr & busy_eff[q_rd]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Decode-to-execute register file access: scoreboard, read sequencing, operand output.
// Accept at edge N gives op_valid from edge N+2; one request per two cycles.
// iss_ready drops on hazard or while operands wait on op_ready; writeback never stalls.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [REG_ADDR_SIZE-1:0] iss_rs1,
    input  logic [REG_ADDR_SIZE-1:0] iss_rs2,
    input  logic [REG_ADDR_SIZE-1:0] iss_rd,
    input  logic                     iss_wr,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [WORD_SIZE-1:0]     op_a,
    output logic [WORD_SIZE-1:0]     op_b,
    output logic [REG_ADDR_SIZE-1:0] op_rd,
    output logic                     op_wr,
    input  logic                     wb_valid,
    input  logic [REG_ADDR_SIZE-1:0] wb_rd,
    input  logic [WORD_SIZE-1:0]     wb_data,
    output logic                     rf_en,
    output logic [REG_ADDR_SIZE-1:0] rf_write,
    output logic [WORD_SIZE-1:0]     rf_data,
    output logic [REG_ADDR_SIZE-1:0] rf_r1,
    output logic [REG_ADDR_SIZE-1:0] rf_r2,
    input  logic [WORD_SIZE-1:0]     rf_out1,
    input  logic [WORD_SIZE-1:0]     rf_out2
);

    rf_state_e                state_q, state_d;
    logic                     en_q, en_d;
    logic [REG_ADDR_SIZE-1:0] rf_r1_q, rf_r1_d;
    logic [REG_ADDR_SIZE-1:0] rf_r2_q, rf_r2_d;
    logic [REG_ADDR_SIZE-1:0] op_rd_q, op_rd_d;
    logic                     op_wr_q, op_wr_d;
    logic [WORD_SIZE-1:0]     op_a_q, op_a_d;
    logic [WORD_SIZE-1:0]     op_b_q, op_b_d;
    logic                     hazard;
    logic                     accept;

    regfile_scoreboard #(
        .ADDR_W (REG_ADDR_SIZE)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && iss_wr),
        .set_addr (iss_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .q_rs1    (iss_rs1),
        .q_rs2    (iss_rs2),
        .q_rd     (iss_rd),
        .q_wr     (iss_wr),
        .hazard   (hazard)
    );

    // en_q keeps the port quiet for the first cycle out of reset.
    always_comb begin
        iss_ready = 1'b0;
        case (state_q)
            ST_IDLE: iss_ready = en_q && !hazard;
            ST_OUT:  iss_ready = en_q && op_ready && !hazard;
            default: iss_ready = 1'b0;
        endcase
    end

    assign accept = iss_valid && iss_ready;

    always_comb begin
        state_d = state_q;
        en_d    = 1'b1;
        rf_r1_d = rf_r1_q;
        rf_r2_d = rf_r2_q;
        op_rd_d = op_rd_q;
        op_wr_d = op_wr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        // Read addresses are loaded at accept so they are stable for the whole READ cycle.
        if (accept) begin
            rf_r1_d = iss_rs1;
            rf_r2_d = iss_rs2;
            op_rd_d = iss_rd;
            op_wr_d = iss_wr;
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: begin
                state_d = ST_OUT;
                op_a_d  = (rf_r1_q == '0) ? '0 : rf_out1;
                op_b_d  = (rf_r2_q == '0) ? '0 : rf_out2;
            end
            ST_OUT:  if (op_ready) state_d = accept ? ST_READ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            rf_r1_q <= '0;
            rf_r2_q <= '0;
            op_rd_q <= '0;
            op_wr_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rf_r1_q <= rf_r1_d;
            rf_r2_q <= rf_r2_d;
            op_rd_q <= op_rd_d;
            op_wr_q <= op_wr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign op_valid = (state_q == ST_OUT);
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_rd    = op_rd_q;
    assign op_wr    = op_wr_q;
    assign rf_en    = en_q;
    assign rf_r1    = rf_r1_q;
    assign rf_r2    = rf_r2_q;
    assign rf_write = (wb_valid && wb_rd != '0) ? wb_rd : '0;
    assign rf_data  = wb_data;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural dual-read register file.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_ready, iss_wr;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd;
    logic        op_valid, op_ready, op_wr;
    logic [63:0] op_a, op_b;
    logic [3:0]  op_rd;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [63:0] wb_data;
    logic        rf_en;
    logic [3:0]  rf_write, rf_r1, rf_r2;
    logic [63:0] rf_data, rf_out1, rf_out2;

    logic [63:0] mem [16];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr(iss_wr),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_en(rf_en), .rf_write(rf_write), .rf_data(rf_data),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out1(rf_out1), .rf_out2(rf_out2)
    );

    // Register file: write on rising edge, read on falling edge, r0 hardwired to zero.
    always @(posedge clk) begin
        if (rf_en && rf_write != 4'd0) mem[rf_write] <= rf_data;
    end

    always @(negedge clk) begin
        rf_out1 <= (rf_r1 == 4'd0) ? 64'd0 : mem[rf_r1];
        rf_out2 <= (rf_r2 == 4'd0) ? 64'd0 : mem[rf_r2];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic wr);
        iss_valid = 1'b1;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_wr    = wr;
    endtask

    task automatic wb(input logic [3:0] rd, input logic [63:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
    endtask

    task automatic drain();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic wait_opv();
        int n = 0;
        while (!op_valid && n < 10) begin
            tick();
            n++;
        end
        chk("op_valid_wait", {63'd0, op_valid}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_wr = 1'b0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #12;
        chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
        chk("rst_iss_ready", {63'd0, iss_ready}, 64'd0);
        chk("rst_rf_en", {63'd0, rf_en}, 64'd0);
        chk("rst_rf_r1", {60'd0, rf_r1}, 64'd0);
        chk("rst_op_a", op_a, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rf_en_after_rst", {63'd0, rf_en}, 64'd1);
        chk("iss_ready_idle", {63'd0, iss_ready}, 64'd1);

        // Preload through the writeback port (non-busy writes still land).
        wb(4'd3, 64'hA); #1;
        chk("rf_write_fwd", {60'd0, rf_write}, 64'd3);
        chk("rf_data_fwd", rf_data, 64'hA);
        tick();
        wb(4'd5, 64'hB);  tick();
        wb(4'd7, 64'h11); tick();
        wb_valid = 1'b0;

        // Basic read: op_valid exactly two edges after accept.
        issue(4'd3, 4'd5, 4'd0, 1'b0); #1;
        chk("t1_iss_ready", {63'd0, iss_ready}, 64'd1);
        tick();
        iss_valid = 1'b0;
        chk("t1_read_no_valid", {63'd0, op_valid}, 64'd0);
        chk("t1_rf_r1", {60'd0, rf_r1}, 64'd3);
        chk("t1_read_not_ready", {63'd0, iss_ready}, 64'd0);
        tick();
        chk("t1_op_valid", {63'd0, op_valid}, 64'd1);
        chk("t1_op_a", op_a, 64'hA);
        chk("t1_op_b", op_b, 64'hB);
        chk("t1_op_wr", {63'd0, op_wr}, 64'd0);
        drain();
        chk("t1_back_idle", {63'd0, op_valid}, 64'd0);

        // RAW hazard on r7, released by a same-cycle writeback.
        issue(4'd3, 4'd5, 4'd7, 1'b1);
        tick();
        iss_valid = 1'b0;
        tick();
        chk("t2_op_rd", {60'd0, op_rd}, 64'd7);
        chk("t2_op_wr", {63'd0, op_wr}, 64'd1);
        drain();
        issue(4'd7, 4'd0, 4'd0, 1'b0); #1;
        chk("t2_stall", {63'd0, iss_ready}, 64'd0);
        tick();
        chk("t2_stall_held", {63'd0, iss_ready}, 64'd0);
        chk("t2_stall_no_valid", {63'd0, op_valid}, 64'd0);
        wb(4'd7, 64'h55); #1;
        chk("t2_wb_release", {63'd0, iss_ready}, 64'd1);
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0;
        tick();
        chk("t2_op_valid", {63'd0, op_valid}, 64'd1);
        chk("t2_op_a", op_a, 64'h55);
        chk("t2_op_b", op_b, 64'd0);
        drain();

        // Writeback to r0 is dropped; r0 operands read as zero.
        wb(4'd0, 64'hFF);
        issue(4'd0, 4'd0, 4'd0, 1'b0); #1;
        chk("t3_rf_write_r0", {60'd0, rf_write}, 64'd0);
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0;
        tick();
        chk("t3_op_a", op_a, 64'd0);
        chk("t3_op_b", op_b, 64'd0);
        drain();

        // Backpressure hold, then back-to-back issue from OUT.
        issue(4'd3, 4'd5, 4'd0, 1'b1); #1;
        chk("t4_r0_not_busy", {63'd0, iss_ready}, 64'd1);
        tick();
        iss_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {63'd0, op_valid}, 64'd1);
            chk("t4_hold_a", op_a, 64'hA);
            chk("t4_hold_b", op_b, 64'hB);
            tick();
        end
        op_ready = 1'b1;
        issue(4'd5, 4'd3, 4'd0, 1'b0); #1;
        chk("t4_out_ready", {63'd0, iss_ready}, 64'd1);
        tick();
        iss_valid = 1'b0; op_ready = 1'b0;
        chk("t4_read_again", {63'd0, op_valid}, 64'd0);
        chk("t4_rf_r1", {60'd0, rf_r1}, 64'd5);
        tick();
        chk("t4_op_a", op_a, 64'hB);
        chk("t4_op_b", op_b, 64'hA);
        drain();

        // Same-cycle set and clear of r4: set wins.
        wb(4'd4, 64'h44);
        issue(4'd3, 4'd5, 4'd4, 1'b1); #1;
        chk("t5_iss_ready", {63'd0, iss_ready}, 64'd1);
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0;
        tick();
        drain();
        issue(4'd4, 4'd0, 4'd0, 1'b0); #1;
        chk("t5_rs1_stall", {63'd0, iss_ready}, 64'd0);
        tick();
        chk("t5_rs1_stall_held", {63'd0, iss_ready}, 64'd0);
        iss_valid = 1'b0;
        iss_rs1 = 4'd0; iss_rd = 4'd4; iss_wr = 1'b1; #1;
        chk("t5_waw_stall", {63'd0, iss_ready}, 64'd0);
        iss_wr = 1'b0; #1;
        chk("t5_rd_no_wr_ok", {63'd0, iss_ready}, 64'd1);
        wb(4'd4, 64'h99);
        issue(4'd4, 4'd0, 4'd0, 1'b0);
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0;
        tick();
        chk("t5_op_a", op_a, 64'h99);
        drain();

        // Reset in the middle of READ.
        issue(4'd3, 4'd5, 4'd9, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_op_valid", {63'd0, op_valid}, 64'd0);
        chk("t6_rst_rf_en", {63'd0, rf_en}, 64'd0);
        chk("t6_rst_iss_ready", {63'd0, iss_ready}, 64'd0);
        chk("t6_rst_rf_r1", {60'd0, rf_r1}, 64'd0);
        rst_n = 1'b1;
        tick();
        issue(4'd3, 4'd5, 4'd9, 1'b1); #1;
        chk("t6_busy_cleared", {63'd0, iss_ready}, 64'd1);
        tick();
        iss_valid = 1'b0;
        wait_opv();
        chk("t6_op_a", op_a, 64'hA);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
